multiword_adder_seq: RTL and testbench

//  Multi-cycle sequencer that computes a WORDS*N-bit add or subtract using one shared N-bit adder_N.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_N.sv | 15 +
 rtl/multiword_adder_seq.sv | 136 +++++++++++++
 tb/tb_multiword_adder_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the limb-serial multiword adder.
package adder_pkg;

    // Sequencer states: wait for a request, walk the limbs, then flag completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } seq_state_t;

    // Width of the limb index; one bit minimum so a single-limb build still has a counter.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder_N.sv
// Plain N-bit ripple adder with carry in and carry out; the only arithmetic in the sequencer.
module adder_N #(
    parameter int N = 4
) (
    output logic [N-1:0] sum,
    output logic         cout,
    input  logic [N-1:0] p,
    input  logic [N-1:0] q,
    input  logic         cin
);

    // Zero-extend everything to N+1 bits so the top bit of the total is the carry out.
    assign {cout, sum} = {1'b0, p} + {1'b0, q} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-cycle WORDS*N-bit add/subtract built around a single shared N-bit adder.
// One limb is processed per clock, least significant limb first, with the limb
// carry held in a flip-flop between cycles.
module multiword_adder_seq
    import adder_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 ready,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W    = N * WORDS;
    localparam int IDXW = idx_width(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    seq_state_t state;
    seq_state_t next_state;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            sub_reg;
    logic [IDXW-1:0] idx;
    logic            carry;

    logic [N-1:0]    limb_p;
    logic [N-1:0]    limb_q;
    logic [N-1:0]    add_sum;
    logic            add_cout;
    logic            last_limb;
    logic            limb_ovf;

    // Single shared limb adder; the carry flop feeds its carry input each cycle.
    adder_N #(.N(N)) u_add (
        .sum  (add_sum),
        .cout (add_cout),
        .p    (limb_p),
        .q    (limb_q),
        .cin  (carry)
    );

    // Limb mux: select the current limb of each operand; subtraction inverts B here
    // and relies on the carry flop having been preset to 1 at start.
    always_comb begin
        limb_p    = a_reg[int'(idx)*N +: N];
        limb_q    = b_reg[int'(idx)*N +: N] ^ {N{sub_reg}};
        last_limb = (idx == LAST_IDX);
        limb_ovf  = (limb_p[N-1] ^ add_sum[N-1]) & (limb_q[N-1] ^ add_sum[N-1]);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore handshake outputs; START outside IDLE is simply dropped.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_limb) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, limb counter, carry chain and result demux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            idx     <= '0;
            carry   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        idx     <= '0;
                        carry   <= sub;
                    end
                end
                RUN: begin
                    result[int'(idx)*N +: N] <= add_sum;
                    carry                    <= add_cout;
                    if (last_limb) begin
                        idx  <= '0;
                        cout <= add_cout;
                        ovf  <= limb_ovf;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq with N=4, WORDS=2 (8-bit operations).
module tb_multiword_adder_seq;

    localparam int N     = 4;
    localparam int WORDS = 2;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int compared;
    int mismatched;
    int done_pulses;
    int starts_issued;

    multiword_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every DONE pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    // Global time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation, optionally poke START mid-run, and check the outcome
    // against plain integer arithmetic.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                 input bit poke, input bit full_checks);
        int       cycles;
        int       waited;
        bit       ready_bad;
        int       sa;
        int       sb;
        int       sres;
        logic [8:0] exp_wide;
        logic       exp_ovf;

        waited = 0;
        while (ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (ready !== 1'b1) checkOutput("ready_timeout", 32'(ready), 32'd1);

        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        starts_issued++;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs; the latched operands must be unaffected.
        a   = 8'($urandom);
        b   = 8'($urandom);
        sub = 1'($urandom);

        ready_bad = (ready !== 1'b0);
        cycles    = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (poke && cycles == 0) begin
                @(negedge clk);
                start = 1'b1;
                a     = 8'h55;
                b     = 8'h22;
                sub   = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (ready !== 1'b0) ready_bad = 1'b1;
        end

        if (sv) exp_wide = {1'b0, av} + {1'b0, ~bv} + 9'd1;
        else    exp_wide = {1'b0, av} + {1'b0, bv};
        sa      = int'($signed(av));
        sb      = int'($signed(bv));
        sres    = sv ? (sa - sb) : (sa + sb);
        exp_ovf = (sres > 127) || (sres < -128);

        checkOutput("result", 32'(result), 32'(exp_wide[7:0]));
        checkOutput("cout",   32'(cout),   32'(exp_wide[8]));
        checkOutput("ovf",    32'(ovf),    32'(exp_ovf));
        if (full_checks) begin
            checkOutput("latency_edges", 32'(cycles), 32'(WORDS));
            checkOutput("ready_low_until_done", 32'(ready_bad), 32'd0);
            @(posedge clk); #1;
            checkOutput("done_single_pulse", 32'(done), 32'd0);
            checkOutput("ready_after_done", 32'(ready), 32'd1);
        end else if (cycles >= 20) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int pulses_before;
        int cycles;
        bit saw_done;

        compared      = 0;
        mismatched    = 0;
        done_pulses   = 0;
        starts_issued = 0;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state.
        #12;
        checkOutput("reset_ready",  32'(ready),  32'd1);
        checkOutput("reset_done",   32'(done),   32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_cout",   32'(cout),   32'd0);
        checkOutput("reset_ovf",    32'(ovf),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset released");

        // Directed cases: limb carry, full ripple, signed overflow, subtract, borrow.
        applyStimulus(8'h3F, 8'h01, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h10, 8'h01, 1'b1, 1'b0, 1'b1);

        // Borrow case with a START poked mid-run; it must be ignored.
        pulses_before = done_pulses;
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("ignored_start_one_done", 32'(done_pulses - pulses_before), 32'd1);
        checkOutput("ignored_start_result",   32'(result), 32'hFF);

        // Reset in the middle of RUN: outputs clear without a clock edge, no DONE follows.
        @(negedge clk);
        start = 1'b1;
        a     = 8'hA5;
        b     = 8'h3C;
        sub   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_ready",  32'(ready),  32'd1);
        checkOutput("async_reset_done",   32'(done),   32'd0);
        checkOutput("async_reset_result", 32'(result), 32'd0);
        pulses_before = done_pulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        cycles   = 0;
        while (cycles < 5) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
            cycles++;
        end
        checkOutput("no_done_after_reset", 32'(saw_done), 32'd0);
        checkOutput("no_pulse_after_reset", 32'(done_pulses - pulses_before), 32'd0);
        applyStimulus(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);

        // Boundary corners.
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Randomised back-to-back operations.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, (i % 50) == 0);
        end

        // One DONE per accepted START (the reset-aborted one produced none).
        repeat (4) @(posedge clk);
        #1;
        checkOutput("done_count", 32'(done_pulses), 32'(starts_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
